// File: rtl/dac_spi_pkg.sv
// ============================================================
// dac_spi_pkg: shared frame geometry, DAC command and FSM encoding.
// Rev 1.0
// ============================================================
`default_nettype none

package dac_spi_pkg;

    localparam int         FRAME_BITS  = 16;
    localparam int         DATA_BITS   = 12;
    localparam int         CMD_BITS    = FRAME_BITS - DATA_BITS;
    localparam logic [3:0] DEFAULT_CMD = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LOAD  = 3'd4
    } state_e;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [CMD_BITS-1:0]  cmd,
        input logic [DATA_BITS-1:0] data
    );
        return {cmd, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_spi_tick.sv
// ============================================================
// dac_spi_tick: CLK_DIV divider emitting a one-cycle tick, restartable.
// Rev 1.0
// ============================================================
`default_nettype none

module dac_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Wrapping on the tick keeps every state entry aligned to count 0.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

`default_nettype wire

// File: rtl/dac_spi_serializer.sv
// ============================================================
// dac_spi_serializer: {CMD,DATA_IN} SPI mode-0 frame plus LDAC strobe.
// Rev 1.0
// ============================================================
`default_nettype none

module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = DEFAULT_CMD
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic                 CS_N,
    output logic                 LDAC_N,
    output logic                 DONE
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [3:0]              bit_cnt_q;
    logic                    sclk_q;
    logic                    mosi_q;
    logic                    cs_n_q;
    logic                    ldac_n_q;
    logic                    done_q;
    logic                    ready_q;
    logic [FRAME_BITS-1:0]   frame_d;
    logic                    tick;

    assign frame_d = make_frame(CMD, DATA_IN);

    // Divider is held at zero while idle so SETUP always starts a fresh count.
    dac_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK       (CLK),
        .RST       (RST),
        .restart_i (state_q == ST_IDLE),
        .tick_o    (tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ldac_n_q  <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (VALID && ready_q) begin
                        shreg_q   <= frame_d;
                        mosi_q    <= frame_d[FRAME_BITS-1];
                        cs_n_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= ST_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // High half ends with the falling edge that advances MOSI;
                    // low half ends with the next rising edge or with HOLD.
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q  <= 1'b0;
                            shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
                            mosi_q  <= (bit_cnt_q == LAST_BIT) ? 1'b0
                                                               : shreg_q[FRAME_BITS-2];
                        end else if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_HOLD;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            sclk_q    <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_n_q   <= 1'b1;
                        ldac_n_q <= 1'b0;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        ldac_n_q <= 1'b1;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign READY  = ready_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;
    assign CS_N   = cs_n_q;
    assign LDAC_N = ldac_n_q;
    assign DONE   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_serializer.sv
// ============================================================
// tb_dac_spi_serializer: timeline model plus directed frame checks.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_dac_spi_serializer;

    localparam int         DA       = 4;
    localparam int         DB       = 2;
    // Packed as {CS_N, SCLK, MOSI, LDAC_N, DONE, READY}
    localparam logic [5:0] IDLE_EXP = 6'b100101;
    localparam logic [5:0] RST_EXP  = 6'b100100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid [2];
    logic [11:0] din   [2];
    logic        ready [2];
    logic        sclk  [2];
    logic        mosi  [2];
    logic        cs_n  [2];
    logic        ldac_n[2];
    logic        done  [2];

    always #5 clk = ~clk;

    dac_spi_serializer #(.CLK_DIV(DA)) u_a (
        .CLK(clk), .RST(rst_n), .DATA_IN(din[0]), .VALID(valid[0]), .READY(ready[0]),
        .SCLK(sclk[0]), .MOSI(mosi[0]), .CS_N(cs_n[0]), .LDAC_N(ldac_n[0]), .DONE(done[0])
    );

    dac_spi_serializer #(.CLK_DIV(DB)) u_b (
        .CLK(clk), .RST(rst_n), .DATA_IN(din[1]), .VALID(valid[1]), .READY(ready[1]),
        .SCLK(sclk[1]), .MOSI(mosi[1]), .CS_N(cs_n[1]), .LDAC_N(ldac_n[1]), .DONE(done[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int dv(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    // Expected outputs kk cycles after the capture edge, from the frame timeline.
    function automatic logic [5:0] exp_at(input int d, input logic [15:0] f, input int kk);
        logic cs, sc, mo, ld, dn, rd;
        int   j, b;
        cs = 1'b1; sc = 1'b0; mo = 1'b0; ld = 1'b1; dn = 1'b0; rd = 1'b0;
        if (kk < d) begin
            cs = 1'b0;
            mo = f[15];
        end else if (kk < 33 * d) begin
            j  = kk - d;
            b  = j / (2 * d);
            cs = 1'b0;
            sc = ((j % (2 * d)) < d);
            if (sc)           mo = f[15 - b];
            else if (b < 15)  mo = f[14 - b];
            else              mo = 1'b0;
        end else if (kk < 34 * d) begin
            cs = 1'b0;
        end else if (kk < 35 * d) begin
            ld = 1'b0;
        end else begin
            dn = 1'b1;
            rd = 1'b1;
        end
        return {cs, sc, mo, ld, dn, rd};
    endfunction

    int          cyc = 0;
    bit          active [2] = '{0, 0};
    int          k      [2] = '{0, 0};
    logic [15:0] frame_m[2] = '{16'h0, 16'h0};
    int          cap_cyc[2] = '{0, 0};
    logic [5:0]  expv   [2] = '{RST_EXP, RST_EXP};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                active[i] = 1'b0;
                expv[i]   = RST_EXP;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (valid[i] && expv[i][0]) begin
                    active[i]  = 1'b1;
                    k[i]       = 0;
                    frame_m[i] = {4'b0011, din[i]};
                    cap_cyc[i] = cyc;
                end else if (active[i]) begin
                    if (k[i] == 35 * dv(i)) active[i] = 1'b0;
                    else                    k[i]++;
                end
                expv[i] = active[i] ? exp_at(dv(i), frame_m[i], k[i]) : IDLE_EXP;
            end
        end
    end

    logic        p_sclk [2] = '{0, 0};
    logic        p_cs   [2] = '{1, 1};
    logic        p_ldac [2] = '{1, 1};
    logic [15:0] shv    [2] = '{16'h0, 16'h0};
    logic [15:0] last_frame[2] = '{16'h0, 16'h0};
    int cs_len[2] = '{0, 0}, last_cs_len[2] = '{0, 0};
    int ldac_len[2] = '{0, 0}, last_ldac_len[2] = '{0, 0}, ldac_pulses[2] = '{0, 0};
    int rises[2] = '{0, 0}, last_rises[2] = '{0, 0}, r0[2] = '{0, 0}, r1[2] = '{0, 0};
    int done_cnt[2] = '{0, 0}, last_done_cyc[2] = '{0, 0};
    logic [15:0] fq0[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_dut%0d_cyc%0d", i, cyc),
                  {cs_n[i], sclk[i], mosi[i], ldac_n[i], done[i], ready[i]}, expv[i]);
            if (!cs_n[i]) cs_len[i]++;
            if (sclk[i] && !p_sclk[i]) begin
                shv[i] = {shv[i][14:0], mosi[i]};
                if (rises[i] == 0) r0[i] = cyc;
                if (rises[i] == 1) r1[i] = cyc;
                rises[i]++;
            end
            if (cs_n[i] && !p_cs[i]) begin
                last_frame[i]  = shv[i];
                last_cs_len[i] = cs_len[i];
                last_rises[i]  = rises[i];
                if (i == 0) fq0.push_back(shv[i]);
                cs_len[i] = 0;
                rises[i]  = 0;
            end
            if (!ldac_n[i]) ldac_len[i]++;
            if (ldac_n[i] && !p_ldac[i]) begin
                last_ldac_len[i] = ldac_len[i];
                ldac_pulses[i]++;
                ldac_len[i] = 0;
            end
            if (done[i]) begin
                done_cnt[i]++;
                last_done_cyc[i] = cyc;
            end
            p_sclk[i] = sclk[i];
            p_cs[i]   = cs_n[i];
            p_ldac[i] = ldac_n[i];
        end
    end

    task automatic wait_done(input int i, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < maxc);
        check($sformatf("done_seen_dut%0d", i), done[i], 1);
        #1;
    endtask

    task automatic send(input int i, input logic [11:0] d);
        check($sformatf("ready_before_send_dut%0d", i), ready[i], 1);
        din[i]   = d;
        valid[i] = 1'b1;
        @(negedge clk);
        #1;
        valid[i] = 1'b0;
    endtask

    int d1, dn, lp;

    initial begin
        valid[0] = 1'b0; valid[1] = 1'b0;
        din[0]   = 12'h0; din[1]   = 12'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", ready[0], 0);
        check("rst_cs_n", cs_n[0], 1);
        check("rst_ldac_n", ldac_n[0], 1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_release_a", ready[0], 1);
        check("ready_after_release_b", ready[1], 1);

        repeat (20) @(negedge clk);
        #1;
        check("idle_cs_n", cs_n[0], 1);
        check("idle_sclk", sclk[0], 0);
        check("idle_ldac_n", ldac_n[0], 1);
        check("idle_ready", ready[0], 1);

        send(0, 12'hA5C);
        wait_done(0, 200);
        check("a5c_model_frame", frame_m[0], 16'h3A5C);
        check("a5c_frame", last_frame[0], 16'h3A5C);
        check("a5c_rises", last_rises[0], 16);
        check("a5c_cs_low", last_cs_len[0], 136);
        check("a5c_ldac_low", last_ldac_len[0], 4);
        check("a5c_done_latency", last_done_cyc[0] - cap_cyc[0], 140);

        fq0.delete();
        din[0]   = 12'h001;
        valid[0] = 1'b1;
        @(negedge clk);
        #1;
        din[0] = 12'hFFF;
        wait_done(0, 200);
        d1 = last_done_cyc[0];
        @(negedge clk);
        #1;
        valid[0] = 1'b0;
        check("b2b_accept_on_done", cap_cyc[0] - d1, 1);
        wait_done(0, 200);
        check("b2b_frames", fq0.size(), 2);
        if (fq0.size() >= 2) begin
            check("b2b_frame0", fq0[0], 16'h3001);
            check("b2b_frame1", fq0[1], 16'h3FFF);
        end

        send(0, 12'h123);
        repeat (40) @(negedge clk);
        #1;
        din[0] = 12'h456;
        wait_done(0, 200);
        check("midshift_frame", last_frame[0], 16'h3123);

        send(0, 12'h0F0);
        repeat (61) @(negedge clk);
        #1;
        check("bit7_sclk_high", sclk[0], 1);
        check("bit7_cs_low", cs_n[0], 0);
        dn = done_cnt[0];
        lp = ldac_pulses[0];
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n[0], 1);
        check("abort_sclk", sclk[0], 0);
        check("abort_ldac_n", ldac_n[0], 1);
        check("abort_ready", ready[0], 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_ready_held", ready[0], 0);
        @(negedge clk);
        #1;
        check("abort_ready_after", ready[0], 1);
        repeat (200) @(negedge clk);
        #1;
        check("abort_no_done", done_cnt[0], dn);
        check("abort_no_ldac", ldac_pulses[0], lp);

        send(1, 12'h800);
        wait_done(1, 200);
        check("div2_frame", last_frame[1], 16'h3800);
        check("div2_done_latency", last_done_cyc[1] - cap_cyc[1], 70);
        check("div2_cs_low", last_cs_len[1], 68);
        check("div2_sclk_period", r1[1] - r0[1], 4);
        check("div2_rises", last_rises[1], 16);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dac_spi_serializer.md
DAC_SPI_SERIALIZER -- requirements
Module: dac_spi_serializer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, CLK cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL provide parameter CMD, default 4'b0011, 4-bit DAC command prefixed to every frame (write-and-update).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DATA_IN  input  12  sample word from the AXI DAC register stage.
REQ-006 SHALL have port VALID  input  1  DATA_IN valid; upstream holds it until accepted.
REQ-007 SHALL have port READY  output  1  block idle, can accept a word.
REQ-008 SHALL have port SCLK  output  1  serial clock to DAC, idles low.
REQ-009 SHALL have port MOSI  output  1  serial data to DAC, MSB first.
REQ-010 SHALL have port CS_N  output  1  DAC chip select / SYNC, active-low.
REQ-011 SHALL have port LDAC_N  output  1  DAC load strobe, active-low.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse when a frame and its LDAC strobe are complete.

Function
REQ-013 SHALL accept a word on the CLK edge where VALID=1 and READY=1; capture {CMD, DATA_IN} as 16-bit frame; READY drops the next cycle.
REQ-014 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> LOAD -> IDLE, all outputs registered.
REQ-015 SETUP: CS_N=0, MOSI=frame[15], SCLK=0, for CLK_DIV cycles.
REQ-016 SHIFT: 16 bits; each bit = SCLK high CLK_DIV cycles, then low CLK_DIV cycles; MOSI changes only on SCLK falling edge (SPI mode 0); DAC samples on rising edge.
REQ-017 SHALL count bits with a 4-bit counter; after 16th falling edge SHALL enter HOLD, MOSI=0.
REQ-018 HOLD: CS_N held 0, SCLK=0, for CLK_DIV cycles; then CS_N=1.
REQ-019 LOAD: CS_N=1, LDAC_N=0 for CLK_DIV cycles.
REQ-020 On leaving LOAD SHALL assert DONE for one cycle and READY=1 in the same cycle; a word offered then is accepted on that edge (back-to-back frames, no gap).
REQ-021 Latency: CS_N low = 34*CLK_DIV cycles; capture to DONE = 35*CLK_DIV cycles (140 at default).
REQ-022 VALID while READY=0 SHALL be ignored; DATA_IN changes mid-frame SHALL NOT alter the frame in flight.
REQ-023 Exactly 16 SCLK rising edges per CS_N low window; no SCLK activity while CS_N=1.
REQ-024 Divider counter SHALL reset to 0 at every state entry; no fractional/wrapped half-periods.

Reset
REQ-025 RST=0 SHALL immediately force: state IDLE, SCLK=0, MOSI=0, CS_N=1, LDAC_N=1, DONE=0, READY=0, counters 0.
REQ-026 READY SHALL rise on the first CLK edge after RST release.
REQ-027 Reset mid-frame SHALL abort the frame with no DONE and no LDAC pulse; the aborted word is not retransmitted.

Structure
REQ-028 Package dac_spi_pkg SHALL hold state encoding, FRAME_BITS=16, DATA_BITS=12, default CMD.
REQ-029 SHALL instantiate one sub-module dac_spi_tick: CLK_DIV counter producing a one-cycle tick, restartable per state.
REQ-030 Total RTL SHALL be one FSM plus shift register, bit counter and dac_spi_tick.

Verification
REQ-031 DATA_IN=12'hA5C, VALID=1, default params -> MOSI stream 16'h3A5C MSB first on 16 SCLK rising edges; CS_N low 136 cycles; LDAC_N low 4 cycles; DONE at cycle 140.
REQ-032 VALID held with 12'h001 then 12'hFFF -> two frames 16'h3001, 16'h3FFF back-to-back; second accepted on DONE cycle.
REQ-033 DATA_IN toggled 12'h123->12'h456 mid-SHIFT -> frame still 16'h3123.
REQ-034 RST low during bit 7 -> CS_N=1, SCLK=0 immediately; no DONE, no LDAC_N pulse; READY=1 one cycle after release.
REQ-035 CLK_DIV=2, DATA_IN=12'h800 -> SCLK period 4 cycles, DONE 70 cycles after capture, frame 16'h3800.
REQ-036 VALID=0 throughout -> CS_N=1, SCLK=0, LDAC_N=1, READY=1 indefinitely.
